hdlc_protocol_monitor: RTL and testbench
========================================

// Module: hdlc_protocol_monitor
// PURPOSE
//   Synthesizable run-time protocol checker for the HDLC controller. Watches the serial Rx/Tx
//   lines and Rx/Tx status strobes, verifies flag/abort detection, end-of-frame generation,
//   Tx zero insertion and the Tx idle pattern, with per-check latencies set by parameters.
//   Keeps saturating per-check error counters, sticky error bits and a maskable interrupt.
//   Sits beside the HDLC core; readable by the CPU for silicon/FPGA self-check.
// PARAMETERS
//   CNT_W      8   width of each per-check error counter (saturating)
//   FLAG_LAT   2   cycles from last flag bit sampled on Rx to required Rx_FlagDetect (1..8)
//   ABORT_LAT  2   cycles from 7th abort '1' sampled on Rx to required Rx_AbortDetect (1..8)
//   EOF_LAT    1   cycles from Rx_ValidFrame falling edge to required Rx_EoF (1..8)
//   IDLE_LEN   8   cycles Tx_ValidFrame must be low before the idle check is armed (>=1)
// PORTS
//   Clk            in   1        system clock, all logic on rising edge
//   Rst            in   1        asynchronous, active-low reset
//   Enable         in   1        1 = checks may arm; 0 = no new checks, pending checks flushed
//   ClearErr       in   1        synchronous clear of counters and sticky bits
//   ErrMask        in   5        1 = suppress that check from ErrIrq (bit order as ErrSticky)
//   Rx             in   1        serial receive line
//   Rx_FlagDetect  in   1        core flag-detected strobe
//   Rx_AbortDetect in   1        core abort-detected strobe
//   Rx_ValidFrame  in   1        core Rx frame-in-progress
//   Rx_EoF         in   1        core Rx end-of-frame strobe
//   Tx             in   1        serial transmit line
//   Tx_ValidFrame  in   1        core Tx frame-in-progress
//   ErrSticky      out  5        [0]flag [1]abort [2]eof [3]zero-insert [4]idle; set on error
//   Err_Flag/Err_Abort/Err_Eof/Err_Zero/Err_Idle  out  CNT_W each  per-check error counts
//   ErrIrq         out  1        registered |(ErrSticky & ~ErrMask)
// BEHAVIOUR
//   Reset: all outputs 0; Rx window = 8'hFF; delay lines, ones/idle counters, prev-valid = 0.
//   Rx window: 8-bit shift reg, new Rx into LSB every cycle regardless of Enable.
//   Flag check: window (oldest..newest) == 0111_1110 at edge t and Enable -> push into FLAG_LAT
//     delay line; at edge t+FLAG_LAT Rx_FlagDetect must be 1, else flag error.
//   Abort check: window == 0111_1111 at edge t and Enable -> at t+ABORT_LAT Rx_AbortDetect must
//     be 1. Further '1's do not re-arm (oldest bit no longer 0).
//   EoF check: prev Rx_ValidFrame=1, now 0, Enable -> at t+EOF_LAT Rx_EoF must be 1.
//   Delay lines are independent shift regs; back-to-back arms each checked separately.
//   Zero-insert: 3-bit ones counter counts consecutive Tx=1 while Tx_ValidFrame; cleared on
//     Tx=0 or !Tx_ValidFrame. Counter==5 and Tx=1 and Tx_ValidFrame and Enable -> zero error,
//     counter cleared (one error per violating run).
//   Idle: counter of consecutive !Tx_ValidFrame cycles, saturates at IDLE_LEN; when at IDLE_LEN,
//     !Tx_ValidFrame, Enable and Tx=0 -> idle error every such cycle.
//   Error event: sticky bit set, counter +1, saturating at 2^CNT_W-1 (no wrap).
//   ClearErr same cycle as an error on a check: event wins -> sticky=1, counter=1 for that check;
//     other checks cleared to 0.
//   Enable=0: all delay lines flushed to 0 next edge, counters/sticky hold; ones/idle counters
//     still track lines so re-enable is immediately valid.
//   ErrIrq: 1-cycle registered from sticky/mask; masking never stops counting.
//   Reset mid-operation: all state returns to reset values asynchronously; no errors generated.
// TESTING
//   Rx = ...1,0,1,1,1,1,1,1,0 with Rx_FlagDetect pulsed 2 cycles after last 0 -> Err_Flag=0.
//   Same flag, Rx_FlagDetect held 0 -> ErrSticky[0]=1, Err_Flag=1 at edge t+2, ErrIrq=1 at t+3.
//   Rx_ValidFrame 1->0, Rx_EoF absent; repeat 300x with CNT_W=8 -> Err_Eof saturates at 255.
//   Tx_ValidFrame=1, Tx=1 for 6 cycles -> Err_Zero=1 once; Tx=1,1,1,1,1,0 -> no error.
//   Tx_ValidFrame=0 for 8 cycles then Tx=0 at cycle 9, ErrMask[4]=1 -> Err_Idle=1, ErrIrq=0.
//   Abort armed, Enable dropped next cycle -> no abort error; ClearErr with concurrent error ->
//   that counter =1, others 0; Rst low mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/hdlc_protocol_monitor_if.sv
// ============================================================================
// hdlc_protocol_monitor_if : HDLC core observation lines and checker results
// Revision: 1.0
// ============================================================================
`default_nettype none

interface hdlc_protocol_monitor_if #(
  parameter int CNT_W = 8
);
  logic             Enable;
  logic             ClearErr;
  logic [4:0]       ErrMask;
  logic             Rx;
  logic             Rx_FlagDetect;
  logic             Rx_AbortDetect;
  logic             Rx_ValidFrame;
  logic             Rx_EoF;
  logic             Tx;
  logic             Tx_ValidFrame;
  logic [4:0]       ErrSticky;
  logic [CNT_W-1:0] Err_Flag;
  logic [CNT_W-1:0] Err_Abort;
  logic [CNT_W-1:0] Err_Eof;
  logic [CNT_W-1:0] Err_Zero;
  logic [CNT_W-1:0] Err_Idle;
  logic             ErrIrq;

  modport master (
    output Enable, ClearErr, ErrMask, Rx, Rx_FlagDetect, Rx_AbortDetect,
           Rx_ValidFrame, Rx_EoF, Tx, Tx_ValidFrame,
    input  ErrSticky, Err_Flag, Err_Abort, Err_Eof, Err_Zero, Err_Idle, ErrIrq
  );

  modport slave (
    input  Enable, ClearErr, ErrMask, Rx, Rx_FlagDetect, Rx_AbortDetect,
           Rx_ValidFrame, Rx_EoF, Tx, Tx_ValidFrame,
    output ErrSticky, Err_Flag, Err_Abort, Err_Eof, Err_Zero, Err_Idle, ErrIrq
  );
endinterface

`default_nettype wire

// File: rtl/hdlc_protocol_monitor.sv
// ============================================================================
// hdlc_protocol_monitor : run-time checker for HDLC flag/abort/EoF/zero/idle
// Revision: 1.0
// ============================================================================
`default_nettype none

module hdlc_protocol_monitor #(
  parameter int CNT_W     = 8,
  parameter int FLAG_LAT  = 2,
  parameter int ABORT_LAT = 2,
  parameter int EOF_LAT   = 1,
  parameter int IDLE_LEN  = 8
) (
  input  logic                  Clk,
  input  logic                  Rst,
  hdlc_protocol_monitor_if.slave mon
);

  localparam int         IDLE_W    = $clog2(IDLE_LEN + 1);
  localparam logic [7:0] FLAG_PAT  = 8'b0111_1110;
  localparam logic [7:0] ABORT_PAT = 8'b0111_1111;

  logic [7:0]           win_q, win_d;
  logic [FLAG_LAT-1:0]  flag_dl_q, flag_dl_d;
  logic [ABORT_LAT-1:0] abort_dl_q, abort_dl_d;
  logic [EOF_LAT-1:0]   eof_dl_q, eof_dl_d;
  logic                 prev_valid_q, prev_valid_d;
  logic [2:0]           ones_q, ones_d;
  logic [IDLE_W-1:0]    idle_q, idle_d;
  logic [4:0]           sticky_q, sticky_d;
  logic [CNT_W-1:0]     cnt_q [5];
  logic [CNT_W-1:0]     cnt_d [5];
  logic                 irq_q, irq_d;

  logic                 flag_arm, abort_arm, eof_arm;
  logic [4:0]           err_ev;
  logic [CNT_W-1:0]     cnt_base;

  always_comb begin
    win_d     = {win_q[6:0], mon.Rx};
    flag_arm  = mon.Enable && (win_d == FLAG_PAT);
    abort_arm = mon.Enable && (win_d == ABORT_PAT);
    eof_arm   = mon.Enable && prev_valid_q && !mon.Rx_ValidFrame;
    prev_valid_d = mon.Rx_ValidFrame;

    // Delay lines shift the arm bit in at the LSB; the MSB is the due check.
    flag_dl_d  = mon.Enable ? FLAG_LAT'({flag_dl_q, flag_arm})    : '0;
    abort_dl_d = mon.Enable ? ABORT_LAT'({abort_dl_q, abort_arm}) : '0;
    eof_dl_d   = mon.Enable ? EOF_LAT'({eof_dl_q, eof_arm})       : '0;

    err_ev    = '0;
    err_ev[0] = mon.Enable && flag_dl_q[FLAG_LAT-1]   && !mon.Rx_FlagDetect;
    err_ev[1] = mon.Enable && abort_dl_q[ABORT_LAT-1] && !mon.Rx_AbortDetect;
    err_ev[2] = mon.Enable && eof_dl_q[EOF_LAT-1]     && !mon.Rx_EoF;
    err_ev[3] = mon.Enable && (ones_q == 3'd5) && mon.Tx && mon.Tx_ValidFrame;
    err_ev[4] = mon.Enable && !mon.Tx_ValidFrame && !mon.Tx &&
                (idle_q == IDLE_W'(IDLE_LEN));

    if (!mon.Tx_ValidFrame || !mon.Tx) begin
      ones_d = 3'd0;
    end else if (err_ev[3]) begin
      ones_d = 3'd0;
    end else if (ones_q != 3'd7) begin
      ones_d = ones_q + 3'd1;
    end else begin
      ones_d = ones_q;
    end

    if (mon.Tx_ValidFrame) begin
      idle_d = '0;
    end else if (idle_q != IDLE_W'(IDLE_LEN)) begin
      idle_d = idle_q + 1'b1;
    end else begin
      idle_d = idle_q;
    end

    // An error in the same cycle as ClearErr restarts that counter at 1.
    cnt_base = '0;
    for (int i = 0; i < 5; i++) begin
      cnt_base = mon.ClearErr ? '0 : cnt_q[i];
      cnt_d[i] = (err_ev[i] && (cnt_base != '1)) ? cnt_base + 1'b1 : cnt_base;
    end
    sticky_d = err_ev | (mon.ClearErr ? 5'd0 : sticky_q);
    irq_d    = |(sticky_q & ~mon.ErrMask);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      win_q        <= 8'hFF;
      flag_dl_q    <= '0;
      abort_dl_q   <= '0;
      eof_dl_q     <= '0;
      prev_valid_q <= 1'b0;
      ones_q       <= 3'd0;
      idle_q       <= '0;
      sticky_q     <= 5'd0;
      irq_q        <= 1'b0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
    end else begin
      win_q        <= win_d;
      flag_dl_q    <= flag_dl_d;
      abort_dl_q   <= abort_dl_d;
      eof_dl_q     <= eof_dl_d;
      prev_valid_q <= prev_valid_d;
      ones_q       <= ones_d;
      idle_q       <= idle_d;
      sticky_q     <= sticky_d;
      irq_q        <= irq_d;
      for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign mon.ErrSticky = sticky_q;
  assign mon.Err_Flag  = cnt_q[0];
  assign mon.Err_Abort = cnt_q[1];
  assign mon.Err_Eof   = cnt_q[2];
  assign mon.Err_Zero  = cnt_q[3];
  assign mon.Err_Idle  = cnt_q[4];
  assign mon.ErrIrq    = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_hdlc_protocol_monitor.sv
// ============================================================================
// tb_hdlc_protocol_monitor : directed self-checking bench for the HDLC monitor
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hdlc_protocol_monitor;

  logic Clk;
  logic Rst;
  int   total;
  int   bad;

  hdlc_protocol_monitor_if #(.CNT_W(8)) bus ();

  hdlc_protocol_monitor #(
    .CNT_W(8), .FLAG_LAT(2), .ABORT_LAT(2), .EOF_LAT(1), .IDLE_LEN(8)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .mon (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic send_flag();
    bus.Rx = 1'b0; step();
    for (int i = 0; i < 6; i++) begin bus.Rx = 1'b1; step(); end
    bus.Rx = 1'b0; step();
  endtask

  task automatic send_abort();
    for (int i = 0; i < 7; i++) begin bus.Rx = 1'b1; step(); end
  endtask

  task automatic rx_zeros();
    bus.Rx = 1'b0;
    for (int i = 0; i < 8; i++) step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    Rst   = 1'b0;
    bus.Enable = 1'b1;        bus.ClearErr = 1'b0;      bus.ErrMask = 5'd0;
    bus.Rx = 1'b1;            bus.Rx_FlagDetect = 1'b0; bus.Rx_AbortDetect = 1'b0;
    bus.Rx_ValidFrame = 1'b0; bus.Rx_EoF = 1'b0;        bus.Tx = 1'b1;
    bus.Tx_ValidFrame = 1'b0;

    #22;
    chk("reset_sticky", bus.ErrSticky, 0);
    chk("reset_flag_cnt", bus.Err_Flag, 0);
    chk("reset_irq", bus.ErrIrq, 0);
    Rst = 1'b1;
    step(); step();
    chk("idle_after_reset", bus.ErrSticky, 0);

    // Flag detected on time
    send_flag();
    step();
    bus.Rx_FlagDetect = 1'b1; step(); bus.Rx_FlagDetect = 1'b0;
    step();
    chk("flag_ok_cnt", bus.Err_Flag, 0);

    // Flag missed: error lands at t+2, interrupt at t+3
    send_flag();
    chk("flag_miss_t0", bus.Err_Flag, 0);
    step();
    chk("flag_miss_t1", bus.Err_Flag, 0);
    step();
    chk("flag_miss_cnt", bus.Err_Flag, 1);
    chk("flag_miss_sticky", bus.ErrSticky, 5'b00001);
    chk("flag_miss_irq_t2", bus.ErrIrq, 0);
    step();
    chk("flag_miss_irq_t3", bus.ErrIrq, 1);

    // Strobe one cycle early still counts as a miss
    send_flag();
    bus.Rx_FlagDetect = 1'b1; step(); bus.Rx_FlagDetect = 1'b0;
    step();
    chk("flag_early_cnt", bus.Err_Flag, 2);

    // Abort detected on time, trailing ones must not re-arm
    rx_zeros();
    send_abort();
    step();
    bus.Rx_AbortDetect = 1'b1; step(); bus.Rx_AbortDetect = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("abort_ok_cnt", bus.Err_Abort, 0);

    rx_zeros();
    send_abort();
    step(); step();
    chk("abort_miss_cnt", bus.Err_Abort, 1);
    chk("abort_miss_sticky", bus.ErrSticky, 5'b00011);

    // Enable dropped right after arming flushes the pending abort check
    rx_zeros();
    send_abort();
    bus.Enable = 1'b0; step();
    bus.Enable = 1'b1; step(); step(); step();
    chk("abort_flushed", bus.Err_Abort, 1);
    rx_zeros();

    // EoF present on time
    bus.Rx_ValidFrame = 1'b1; step();
    bus.Rx_ValidFrame = 1'b0; step();
    bus.Rx_EoF = 1'b1; step(); bus.Rx_EoF = 1'b0;
    chk("eof_ok_cnt", bus.Err_Eof, 0);

    // EoF missing repeatedly: counter saturates
    for (int n = 1; n <= 300; n++) begin
      bus.Rx_ValidFrame = 1'b1; step();
      bus.Rx_ValidFrame = 1'b0; step();
      step();
      if (n == 1)   chk("eof_miss_first", bus.Err_Eof, 1);
      if (n == 254) chk("eof_miss_254", bus.Err_Eof, 254);
    end
    chk("eof_saturated", bus.Err_Eof, 255);
    chk("eof_sticky", bus.ErrSticky[2], 1);

    // Zero insertion: six ones is one error, five ones then zero is fine
    bus.Tx_ValidFrame = 1'b1; bus.Tx = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("zero_five_ones", bus.Err_Zero, 0);
    step();
    chk("zero_six_ones", bus.Err_Zero, 1);
    bus.Tx = 1'b0; step();
    bus.Tx = 1'b1;
    for (int i = 0; i < 5; i++) step();
    bus.Tx = 1'b0; step();
    chk("zero_legal_run", bus.Err_Zero, 1);
    bus.Tx_ValidFrame = 1'b0; bus.Tx = 1'b1;

    // ClearErr wipes counters and sticky bits
    bus.ClearErr = 1'b1; step(); bus.ClearErr = 1'b0;
    chk("clear_sticky", bus.ErrSticky, 0);
    chk("clear_eof", bus.Err_Eof, 0);
    chk("clear_zero", bus.Err_Zero, 0);
    step();
    chk("clear_irq", bus.ErrIrq, 0);

    // Idle check arms only after IDLE_LEN idle cycles; masked from irq
    bus.ErrMask = 5'b10000;
    bus.Tx_ValidFrame = 1'b1; step();
    bus.Tx_ValidFrame = 1'b0;
    for (int i = 0; i < 7; i++) step();
    bus.Tx = 1'b0; step();
    chk("idle_not_armed", bus.Err_Idle, 0);
    step();
    bus.Tx = 1'b1;
    chk("idle_err_cnt", bus.Err_Idle, 1);
    chk("idle_err_sticky", bus.ErrSticky, 5'b10000);
    step();
    chk("idle_masked_irq", bus.ErrIrq, 0);
    bus.ErrMask = 5'd0; step();
    chk("idle_unmasked_irq", bus.ErrIrq, 1);

    // Error concurrent with ClearErr keeps that check at 1
    bus.Tx = 1'b0; step(); bus.Tx = 1'b1;
    chk("idle_second_err", bus.Err_Idle, 2);
    bus.Rx_ValidFrame = 1'b1; step();
    bus.Rx_ValidFrame = 1'b0; step(); step();
    chk("eof_before_clear", bus.Err_Eof, 1);
    bus.Tx = 1'b0; bus.ClearErr = 1'b1; step();
    bus.Tx = 1'b1; bus.ClearErr = 1'b0;
    chk("clr_concurrent_idle", bus.Err_Idle, 1);
    chk("clr_concurrent_eof", bus.Err_Eof, 0);
    chk("clr_concurrent_sticky", bus.ErrSticky, 5'b10000);

    // Asynchronous reset mid-frame
    bus.Tx_ValidFrame = 1'b1; bus.Rx_ValidFrame = 1'b1; step();
    #3 Rst = 1'b0;
    #1;
    chk("rst_async_sticky", bus.ErrSticky, 0);
    chk("rst_async_idle", bus.Err_Idle, 0);
    chk("rst_async_irq", bus.ErrIrq, 0);
    bus.Tx_ValidFrame = 1'b0; bus.Rx_ValidFrame = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("post_rst_sticky", bus.ErrSticky, 0);
    chk("post_rst_irq", bus.ErrIrq, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
